// File: rtl/uart_byte_tx.sv
// Byte serialiser for the UART TX line: start bit, 8 data bits LSB first,
// optional parity bit, then 1 or 2 stop bits. Returns a one-cycle tx_done per frame.
module uart_byte_tx #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       send_en,
   input  logic [7:0] data_byte,
   output logic       uart_tx,
   output logic       tx_done,
   output logic       tx_busy
);

   // state   | meaning
   // IDLE    | line high, waiting for send_en
   // START   | start bit (line low)
   // DATA    | data bits 0..7, LSB first
   // PARITY  | parity bit (only when PARITY_EN)
   // STOP    | stop bit(s), line high

   localparam int BAUD_DIV = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int CW       = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t          state;
   logic [7:0]      shreg;
   logic            par_bit;
   logic [CW-1:0]   baud_cnt;
   logic [2:0]      bit_idx;
   logic            stop_cnt;
   logic            last_stop;

   assign last_stop = (STOP_BITS == 1) || stop_cnt;

   // baud_cnt is a down-counter; a bit period ends on its terminal count of zero
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         uart_tx  <= 1'b1;
         tx_done  <= 1'b0;
         tx_busy  <= 1'b0;
         shreg    <= 8'h00;
         par_bit  <= 1'b0;
         baud_cnt <= '0;
         bit_idx  <= 3'd0;
         stop_cnt <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            IDLE: begin
               uart_tx <= 1'b1;
               tx_busy <= 1'b0;
               if (send_en) begin
                  shreg    <= data_byte;
                  par_bit  <= (^data_byte) ^ (PARITY_ODD != 0);
                  baud_cnt <= BAUD_LAST;
                  bit_idx  <= 3'd0;
                  stop_cnt <= 1'b0;
                  uart_tx  <= 1'b0;
                  tx_busy  <= 1'b1;
                  state    <= START;
               end
            end
            START: begin
               if (baud_cnt == '0) begin
                  baud_cnt <= BAUD_LAST;
                  uart_tx  <= shreg[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt - CW'(1);
               end
            end
            DATA: begin
               if (baud_cnt == '0) begin
                  baud_cnt <= BAUD_LAST;
                  if (bit_idx == 3'd7) begin
                     if (PARITY_EN != 0) begin
                        uart_tx <= par_bit;
                        state   <= PARITY;
                     end else begin
                        uart_tx <= 1'b1;
                        state   <= STOP;
                     end
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     uart_tx <= shreg[bit_idx + 3'd1];
                  end
               end else begin
                  baud_cnt <= baud_cnt - CW'(1);
               end
            end
            PARITY: begin
               if (baud_cnt == '0) begin
                  baud_cnt <= BAUD_LAST;
                  uart_tx  <= 1'b1;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt - CW'(1);
               end
            end
            STOP: begin
               uart_tx <= 1'b1;
               if (baud_cnt == '0) begin
                  if (last_stop) begin
                     tx_busy <= 1'b0;
                     tx_done <= 1'b1;
                     state   <= IDLE;
                  end else begin
                     stop_cnt <= 1'b1;
                     baud_cnt <= BAUD_LAST;
                  end
               end else begin
                  baud_cnt <= baud_cnt - CW'(1);
               end
            end
            default: begin
               uart_tx <= 1'b1;
               tx_busy <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Four transmitter variants driven from shared inputs, each checked every cycle
// against a line-level waveform model built from the frame format.
module tb_uart_byte_tx;

   localparam int D = 10;
   localparam int PE[4] = '{0, 1, 1, 0};
   localparam int PO[4] = '{0, 0, 1, 0};
   localparam int SB[4] = '{1, 1, 1, 2};

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       send_en = 1'b0;
   logic [7:0] data_byte = 8'h00;
   logic [3:0] tx_line, done, busy;

   int total = 0;
   int bad = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   uart_byte_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
      .clk(clk), .reset_n(reset_n), .send_en(send_en), .data_byte(data_byte),
      .uart_tx(tx_line[0]), .tx_done(done[0]), .tx_busy(busy[0]));
   uart_byte_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .send_en(send_en), .data_byte(data_byte),
      .uart_tx(tx_line[1]), .tx_done(done[1]), .tx_busy(busy[1]));
   uart_byte_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
      .clk(clk), .reset_n(reset_n), .send_en(send_en), .data_byte(data_byte),
      .uart_tx(tx_line[2]), .tx_done(done[2]), .tx_busy(busy[2]));
   uart_byte_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut3 (
      .clk(clk), .reset_n(reset_n), .send_en(send_en), .data_byte(data_byte),
      .uart_tx(tx_line[3]), .tx_done(done[3]), .tx_busy(busy[3]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: per variant, a queue holding the expected line level of every
   // remaining cycle of the frame in flight (empty = idle).
   bit q[4][$];
   bit dexp[4];

   function automatic void push_bit(input int i, input bit v);
      for (int k = 0; k < D; k++) q[i].push_back(v);
   endfunction

   function automatic void push_frame(input int i, input logic [7:0] b);
      push_bit(i, 1'b0);
      for (int k = 0; k < 8; k++) push_bit(i, b[k]);
      if (PE[i] != 0) push_bit(i, (^b) ^ (PO[i] != 0));
      for (int k = 0; k < SB[i]; k++) push_bit(i, 1'b1);
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) begin
            q[i].delete();
            dexp[i] = 1'b0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            bit was;
            was = (q[i].size() != 0);
            if (was) void'(q[i].pop_front());
            dexp[i] = was && (q[i].size() == 0);
            if (!was && send_en) push_frame(i, data_byte);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("line%0d", i), tx_line[i], (q[i].size() != 0) ? q[i][0] : 1'b1);
            chk($sformatf("busy%0d", i), busy[i], q[i].size() != 0);
            chk($sformatf("done%0d", i), done[i], dexp[i]);
         end
      end
   end

   // One frame from idle on all variants; records the tx_done cycle of each
   // (cycle 1 = first start-bit cycle) and the line level during the parity bit.
   task automatic run_frame(input logic [7:0] b);
      int got[4];
      logic p1, p2;
      got = '{default: 0};
      p1 = 1'bx;
      p2 = 1'bx;
      @(posedge clk); #1;
      send_en = 1'b1;
      data_byte = b;
      @(posedge clk); #1;
      send_en = 1'b0;
      data_byte = 8'($urandom);
      for (int c = 1; c <= 200; c++) begin
         for (int i = 0; i < 4; i++) if (done[i] && got[i] == 0) got[i] = c;
         if (c == 95) begin
            p1 = tx_line[1];
            p2 = tx_line[2];
         end
         @(posedge clk); #1;
      end
      for (int i = 0; i < 4; i++)
         chk($sformatf("done_cycle%0d", i), got[i], 1 + D * (9 + PE[i] + SB[i]));
      chk("parity_even", p1, ^b);
      chk("parity_odd", p2, ~^b);
   endtask

   initial begin
      int n, ndone;
      logic [7:0] rb;

      repeat (3) @(posedge clk);
      #1;
      chk_on = 1'b1;
      chk("reset_line", tx_line, 4'hF);
      chk("reset_busy", busy, 4'h0);
      chk("reset_done", done, 4'h0);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);

      // basic frame, parity variants, two stop bits
      run_frame(8'hA5);
      run_frame(8'h07);
      run_frame(8'hFF);

      // send_en while busy is ignored; send_en in the tx_done cycle is taken
      @(posedge clk); #1;
      send_en = 1'b1;
      data_byte = 8'h3C;
      @(posedge clk); #1;
      send_en = 1'b0;
      n = 1;
      ndone = 0;
      while (n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      send_en = 1'b1;
      data_byte = 8'hC3;
      @(posedge clk); #1;
      send_en = 1'b0;
      n++;
      while (!done[0] && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("busy_ignore_done_cycle", n, 101);
      send_en = 1'b1;
      data_byte = 8'h5A;
      @(posedge clk); #1;
      send_en = 1'b0;
      chk("b2b_start_line", tx_line[0], 1'b0);
      chk("b2b_start_busy", busy[0], 1'b1);
      for (int c = 0; c < 200; c++) begin
         if (done[0]) ndone++;
         @(posedge clk); #1;
      end
      chk("b2b_done_count", ndone, 1);

      // reset mid-frame
      @(posedge clk); #1;
      send_en = 1'b1;
      data_byte = 8'h96;
      @(posedge clk); #1;
      send_en = 1'b0;
      repeat (54) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("midreset_line", tx_line, 4'hF);
      chk("midreset_busy", busy, 4'h0);
      chk("midreset_done", done, 4'h0);
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      ndone = 0;
      for (int c = 0; c < 150; c++) begin
         if (done != 4'h0) ndone++;
         @(posedge clk); #1;
      end
      chk("midreset_no_done", ndone, 0);
      run_frame(8'($urandom));

      // random bytes back-to-back on the no-parity, one-stop variant
      @(posedge clk); #1;
      for (int k = 0; k < 20; k++) begin
         rb = 8'($urandom_range(0, 255));
         send_en = 1'b1;
         data_byte = rb;
         @(posedge clk); #1;
         send_en = 1'b0;
         data_byte = 8'($urandom);
         n = 1;
         while (!done[0] && n < 200) begin
            @(posedge clk); #1;
            n++;
         end
         chk($sformatf("rand_gap%0d", k), n, 101);
      end
      repeat (150) @(posedge clk);
      #1;
      chk("final_idle", busy, 4'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
